// File: rtl/aes_encrypt_iter_pkg.sv
// Shared AES encrypt definitions: FSM encoding, S-box, GF(2^8) helpers, round-key slice.
`define AES_RK_SLICE(ks, r) ks[128*(r) +: 128]

package aes_encrypt_iter_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned NB_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_encrypt_iter_round
    import aes_encrypt_iter_pkg::*;
(
    input  logic [0:BLOCK_W-1] s,
    input  logic [0:BLOCK_W-1] rk,
    input  logic               last,
    output logic [0:BLOCK_W-1] y
);

    logic [7:0] sb [NB_BYTES];
    logic [7:0] sr [NB_BYTES];
    logic [7:0] mx [NB_BYTES];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[s[8*i +: 8]];
        end
    end

    // Byte 4c+r sits in column c, row r; row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mx[4*c]     = xtime(sr[4*c])   ^ gf_mul3(sr[4*c+1]) ^ sr[4*c+2]          ^ sr[4*c+3];
            mx[4*c + 1] = sr[4*c]          ^ xtime(sr[4*c+1])   ^ gf_mul3(sr[4*c+2]) ^ sr[4*c+3];
            mx[4*c + 2] = sr[4*c]          ^ sr[4*c+1]          ^ xtime(sr[4*c+2])   ^ gf_mul3(sr[4*c+3]);
            mx[4*c + 3] = gf_mul3(sr[4*c]) ^ sr[4*c+1]          ^ sr[4*c+2]          ^ xtime(sr[4*c+3]);
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            y[8*i +: 8] = (last ? sr[i] : mx[i]) ^ rk[8*i +: 8];
        end
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES block encryptor, one round per clock, start/done handshake.
module aes_encrypt_iter
    import aes_encrypt_iter_pkg::*;
#(
    parameter int unsigned nk = 4,
    parameter int unsigned nr = nk + 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [0:BLOCK_W-1]          Message,
    input  logic [0:BLOCK_W*(nr+1)-1]   keySchedule,
    output logic                        ready,
    output logic                        done,
    output logic [0:BLOCK_W-1]          cipher
);

    localparam int unsigned RW = $clog2(nr + 2);

    aes_state_e         state_q, state_d;
    logic [RW-1:0]      round_q, round_d;
    logic [0:BLOCK_W-1] state_reg_q, state_reg_d;
    logic [0:BLOCK_W-1] cipher_q, cipher_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    logic [0:BLOCK_W-1] rk_tab [nr+1];
    logic [RW-1:0]      rk_idx;
    logic [0:BLOCK_W-1] rk_sel;
    logic               last_round;
    logic [0:BLOCK_W-1] round_y;

    for (genvar r = 0; r < nr + 1; r++) begin : g_rk
        assign rk_tab[r] = `AES_RK_SLICE(keySchedule, r);
    end

    // Round key 0 feeds the initial whitening XOR when a block is accepted.
    assign rk_idx     = (state_q == ST_RUN) ? round_q : '0;
    assign rk_sel     = rk_tab[rk_idx];
    assign last_round = (round_q == RW'(nr));

    aes_encrypt_iter_round u_round (
        .s    (state_reg_q),
        .rk   (rk_sel),
        .last (last_round),
        .y    (round_y)
    );

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        state_reg_d = state_reg_q;
        cipher_d    = cipher_q;
        done_d      = 1'b0;
        ready_d     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_reg_d = Message ^ rk_sel;
                    round_d     = RW'(1);
                    state_d     = ST_RUN;
                end else begin
                    round_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                state_reg_d = round_y;
                round_d     = round_q + RW'(1);
                if (last_round) begin
                    cipher_d = round_y;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                round_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            round_q     <= '0;
            state_reg_q <= '0;
            cipher_q    <= '0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            state_reg_q <= state_reg_d;
            cipher_q    <= cipher_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign cipher = cipher_q;

endmodule
